pht_update_queue: RTL and testbench

Branch-resolution side of the BPU. Records the PHT index and counter snapshot of every conditional branch the direction predictor predicts, holds them in program order until execute resolves each branch, then issues the 2-bit saturating-counter update and the GHR shift that the direction predictor consumes on its PHT/GHR write ports. It also flags mispredictions and keeps in-flight counter snapshots coherent with updates that have already been written.

---
 rtl/bpu_pkg.sv | 26 ++
 rtl/pht_update_queue.sv | 163 ++++++++++++++++
 tb/tb_pht_update_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared branch-prediction definitions: counter encoding, PHT geometry and
// the 2-bit saturating counter update.
package bpu_pkg;

  localparam int unsigned PHT_IDX_W = 11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Next counter value after a resolved branch, saturating at SNT/ST.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pht_update_queue.sv
// In-order queue of predicted conditional branches. On resolve it issues the
// PHT counter update and GHR shift, flags mispredictions and keeps the
// counter snapshots of younger in-flight entries coherent with the write.
module pht_update_queue
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = PHT_IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BPU__Stall,
  input  logic             Pred_Valid,
  input  logic [IDX_W-1:0] Pred_Index,
  input  logic [1:0]       Pred_Counter,
  input  logic             Resolve_Valid,
  input  logic             Resolve_Taken,
  input  logic             Flush,
  output logic [IDX_W-1:0] PHT_Write_Index,
  output logic [1:0]       PHT_Write_Data,
  output logic             PHT_Write_En,
  output logic             GHR_Write_Data,
  output logic             GHR_Write_En,
  output logic             Mispredict,
  output logic             Queue_Full,
  output logic             Queue_Empty,
  output logic             Error_Sticky
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];
  logic [1:0]       ctr_q [DEPTH];
  logic [1:0]       ctr_d [DEPTH];

  logic [IDX_W-1:0] pht_idx_q, pht_idx_d;
  logic [1:0]       pht_data_q, pht_data_d;
  logic             pht_en_q, pht_en_d;
  logic             ghr_data_q, ghr_data_d;
  logic             ghr_en_q, ghr_en_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  logic             full_c, empty_c;
  logic [IDX_W-1:0] head_idx_c;
  logic [1:0]       head_ctr_c, new_ctr_c;
  logic             pop_c, push_c, wr_c, mis_c, overflow_c, underflow_c;
  logic [PTR_W-1:0] offset_c;

  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign Queue_Full  = full_c;
  assign Queue_Empty = empty_c;

  // Resolve/enqueue decode for the head entry.
  always_comb begin
    head_idx_c  = idx_q[head_q];
    head_ctr_c  = ctr_q[head_q];
    new_ctr_c   = sat_update(head_ctr_c, Resolve_Taken);
    pop_c       = Resolve_Valid && !empty_c;
    wr_c        = pop_c && (new_ctr_c != head_ctr_c);
    mis_c       = pop_c && (Resolve_Taken != head_ctr_c[1]);
    push_c      = Pred_Valid && !Flush && !mis_c && (!full_c || pop_c);
    overflow_c  = Pred_Valid && !Flush && full_c && !pop_c;
    underflow_c = Resolve_Valid && empty_c;
  end

  // Next-state for pointers, entries (with snapshot coherence) and outputs.
  always_comb begin
    head_d     = head_q + PTR_W'(pop_c);
    tail_d     = tail_q + PTR_W'(push_c);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    idx_d      = idx_q;
    ctr_d      = ctr_q;
    offset_c   = '0;
    pht_idx_d  = pht_idx_q;
    pht_data_d = pht_data_q;
    ghr_data_d = ghr_data_q;
    pht_en_d   = wr_c;
    ghr_en_d   = pop_c;
    mis_d      = mis_c;
    err_d      = err_q || overflow_c || underflow_c;

    if (pop_c) begin
      pht_idx_d  = head_idx_c;
      pht_data_d = new_ctr_c;
      ghr_data_d = Resolve_Taken;
    end

    // Entries still queued behind the head take the freshly written counter.
    if (wr_c) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset_c = PTR_W'(i) - head_q;
        if ((offset_c != '0) && (CNT_W'(offset_c) < count_q) &&
            (idx_q[i] == head_idx_c)) begin
          ctr_d[i] = new_ctr_c;
        end
      end
    end

    if (push_c) begin
      idx_d[tail_q] = Pred_Index;
      ctr_d[tail_q] = (wr_c && (Pred_Index == head_idx_c)) ? new_ctr_c : Pred_Counter;
    end

    if (Flush) begin
      count_d = '0;
      head_d  = tail_q;
      tail_d  = tail_q;
    end else if (mis_c) begin
      count_d = '0;
      tail_d  = head_d;
    end
  end

  // Pointer, count and output registers; stall freezes everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pht_idx_q  <= '0;
      pht_data_q <= '0;
      pht_en_q   <= 1'b0;
      ghr_data_q <= 1'b0;
      ghr_en_q   <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (!BPU__Stall) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pht_idx_q  <= pht_idx_d;
      pht_data_q <= pht_data_d;
      pht_en_q   <= pht_en_d;
      ghr_data_q <= ghr_data_d;
      ghr_en_q   <= ghr_en_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  // Entry storage; contents are don't-care after reset so it is not cleared.
  always_ff @(posedge CLK) begin
    if (!RST && !BPU__Stall) begin
      idx_q <= idx_d;
      ctr_q <= ctr_d;
    end
  end

  assign PHT_Write_Index = pht_idx_q;
  assign PHT_Write_Data  = pht_data_q;
  assign PHT_Write_En    = pht_en_q;
  assign GHR_Write_Data  = ghr_data_q;
  assign GHR_Write_En    = ghr_en_q;
  assign Mispredict      = mis_q;
  assign Error_Sticky    = err_q;

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed cycle-by-cycle vectors for pht_update_queue plus reset corner cases.
module tb_pht_update_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BPU__Stall = 1'b0;
  logic        Pred_Valid = 1'b0;
  logic [10:0] Pred_Index = '0;
  logic [1:0]  Pred_Counter = '0;
  logic        Resolve_Valid = 1'b0;
  logic        Resolve_Taken = 1'b0;
  logic        Flush = 1'b0;
  logic [10:0] PHT_Write_Index;
  logic [1:0]  PHT_Write_Data;
  logic        PHT_Write_En;
  logic        GHR_Write_Data;
  logic        GHR_Write_En;
  logic        Mispredict;
  logic        Queue_Full;
  logic        Queue_Empty;
  logic        Error_Sticky;

  int n_cmp  = 0;
  int n_fail = 0;

  pht_update_queue #(.DEPTH(8), .IDX_W(11)) dut (
    .CLK(CLK), .RST(RST), .BPU__Stall(BPU__Stall),
    .Pred_Valid(Pred_Valid), .Pred_Index(Pred_Index), .Pred_Counter(Pred_Counter),
    .Resolve_Valid(Resolve_Valid), .Resolve_Taken(Resolve_Taken), .Flush(Flush),
    .PHT_Write_Index(PHT_Write_Index), .PHT_Write_Data(PHT_Write_Data),
    .PHT_Write_En(PHT_Write_En), .GHR_Write_Data(GHR_Write_Data),
    .GHR_Write_En(GHR_Write_En), .Mispredict(Mispredict),
    .Queue_Full(Queue_Full), .Queue_Empty(Queue_Empty), .Error_Sticky(Error_Sticky)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic st, pv; logic [10:0] pi; logic [1:0] pc; logic rv, rt, fl;
    logic pe; logic [10:0] pidx; logic [1:0] pd; logic ge, gd, mi, fu, em, er;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic st, input logic pv, input logic [10:0] pi,
                             input logic [1:0] pc, input logic rv, input logic rt,
                             input logic fl, input logic pe, input logic [10:0] pidx,
                             input logic [1:0] pd, input logic ge, input logic gd,
                             input logic mi, input logic fu, input logic em,
                             input logic er);
    vec_t x;
    x.st = st; x.pv = pv; x.pi = pi; x.pc = pc; x.rv = rv; x.rt = rt; x.fl = fl;
    x.pe = pe; x.pidx = pidx; x.pd = pd; x.ge = ge; x.gd = gd; x.mi = mi;
    x.fu = fu; x.em = em; x.er = er;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic pv, input logic [10:0] pi,
                       input logic [1:0] pc, input logic rv, input logic rt, input logic fl);
    BPU__Stall = st; Pred_Valid = pv; Pred_Index = pi; Pred_Counter = pc;
    Resolve_Valid = rv; Resolve_Taken = rt; Flush = fl;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    BPU__Stall = 0; Pred_Valid = 0; Pred_Index = '0; Pred_Counter = '0;
    Resolve_Valid = 0; Resolve_Taken = 0; Flush = 0;
  endtask

  task automatic chk_all(input string tag, input logic pe, input logic [10:0] pidx,
                         input logic [1:0] pd, input logic ge, input logic gd,
                         input logic mi, input logic fu, input logic em, input logic er);
    chk({tag, ".pht_en"}, 32'(PHT_Write_En), 32'(pe));
    chk({tag, ".ghr_en"}, 32'(GHR_Write_En), 32'(ge));
    chk({tag, ".mispredict"}, 32'(Mispredict), 32'(mi));
    chk({tag, ".full"}, 32'(Queue_Full), 32'(fu));
    chk({tag, ".empty"}, 32'(Queue_Empty), 32'(em));
    chk({tag, ".err"}, 32'(Error_Sticky), 32'(er));
    if (pe) begin
      chk({tag, ".pht_idx"}, 32'(PHT_Write_Index), 32'(pidx));
      chk({tag, ".pht_data"}, 32'(PHT_Write_Data), 32'(pd));
    end
    if (ge) chk({tag, ".ghr_data"}, 32'(GHR_Write_Data), 32'(gd));
  endtask

  initial begin
    //           st pv pi      pc    rv rt fl | pe pidx    pd    ge gd mi fu em er
    // first branch: weakly NT, resolves taken -> write 10, mispredict
    vq.push_back(v(0, 1, 11'h05A, 2'b01, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 1, 0, 1, 11'h05A, 2'b10, 1, 1, 1, 0, 1, 0));
    // saturated ST taken -> no PHT write, GHR still shifts
    vq.push_back(v(0, 1, 11'h100, 2'b11, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 1, 0, 0, 11'h000, 2'b00, 1, 1, 0, 0, 1, 0));
    // two WT at 0x020, first not taken -> 01, mispredict clears the younger one
    vq.push_back(v(0, 1, 11'h020, 2'b10, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 11'h020, 2'b10, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 0, 0, 1, 11'h020, 2'b01, 1, 0, 1, 0, 1, 0));
    // repeat, first taken -> 11; second snapshot becomes 11, not taken -> 10
    vq.push_back(v(0, 1, 11'h020, 2'b10, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 11'h020, 2'b10, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 1, 0, 1, 11'h020, 2'b11, 1, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 0, 0, 1, 11'h020, 2'b10, 1, 0, 1, 0, 1, 0));
    // fill eight WT entries 0x200..0x207
    for (int k = 0; k < 8; k++)
      vq.push_back(v(0, 1, 11'(32'h200 + k), 2'b10, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0,
                     (k == 7) ? 1'b1 : 1'b0, 0, 0));
    // ninth enqueue alone -> dropped, sticky error
    vq.push_back(v(0, 1, 11'h3FF, 2'b01, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 1, 0, 1));
    // enqueue while full with resolve of 0x200 -> accepted, still full
    vq.push_back(v(0, 1, 11'h3FF, 2'b00, 1, 1, 0, 1, 11'h200, 2'b11, 1, 1, 0, 1, 0, 1));
    // stall during active strobes -> strobes held, resolve ignored
    vq.push_back(v(1, 0, 11'h000, 2'b00, 1, 1, 0, 1, 11'h200, 2'b11, 1, 1, 0, 1, 0, 1));
    vq.push_back(v(1, 0, 11'h000, 2'b00, 1, 1, 0, 1, 11'h200, 2'b11, 1, 1, 0, 1, 0, 1));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 1, 0, 1));
    // resolve under stall -> nothing; released -> strobes for 0x201
    vq.push_back(v(1, 0, 11'h000, 2'b00, 1, 1, 0, 0, 11'h000, 2'b00, 0, 0, 0, 1, 0, 1));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 1, 0, 1, 11'h201, 2'b11, 1, 1, 0, 0, 0, 1));
    // flush, then 3-entry queue flushed together with resolve and enqueue
    vq.push_back(v(0, 0, 11'h000, 2'b00, 0, 0, 1, 0, 11'h000, 2'b00, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(0, 1, 11'h010, 2'b01, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(0, 1, 11'h011, 2'b01, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(0, 1, 11'h012, 2'b01, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(0, 1, 11'h013, 2'b11, 1, 0, 1, 1, 11'h010, 2'b00, 1, 0, 0, 0, 1, 1));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 1, 1));
    // resolve on empty ignored, same-cycle enqueue kept; SNT not taken -> no write
    vq.push_back(v(0, 1, 11'h0AA, 2'b00, 1, 1, 0, 0, 11'h000, 2'b00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 11'h000, 2'b00, 1, 0, 0, 0, 11'h000, 2'b00, 1, 0, 0, 0, 1, 1));

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 0, 11'h000, 2'b00, 0, 0, 0, 0, 1, 0);
    RST = 0;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].pv, vq[i].pi, vq[i].pc, vq[i].rv, vq[i].rt, vq[i].fl);
      chk_all($sformatf("v%0d", i), vq[i].pe, vq[i].pidx, vq[i].pd, vq[i].ge, vq[i].gd,
              vq[i].mi, vq[i].fu, vq[i].em, vq[i].er);
    end

    // reset mid-operation with stall and resolve pending: clears everything
    drive(0, 1, 11'h055, 2'b10, 0, 0, 0);
    drive(0, 1, 11'h056, 2'b10, 1, 1, 0);
    chk_all("pre_rst", 1, 11'h055, 2'b11, 1, 1, 0, 0, 0, 1);
    RST = 1;
    drive(1, 0, 11'h000, 2'b00, 1, 1, 0);
    chk_all("mid_rst", 0, 11'h000, 2'b00, 0, 0, 0, 0, 1, 0);
    RST = 0;
    // resolve on empty from a clean state sets the sticky error
    drive(0, 0, 11'h000, 2'b00, 1, 1, 0);
    chk_all("underflow", 0, 11'h000, 2'b00, 0, 0, 0, 0, 1, 1);
    idle_inputs();
    drive(0, 0, 11'h000, 2'b00, 0, 0, 0);
    chk_all("sticky_hold", 0, 11'h000, 2'b00, 0, 0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
